// File: rtl/hdmi_timing_pkg.sv
// hdmi_timing_pkg: shared types and constants for the HDMI raster/test-pattern source.
// Holds the pattern select codes, the eight colour-bar constants, the RGB field
// positions inside a 24-bit {R,G,B} pixel, and a bar-index -> colour lookup.
package hdmi_timing_pkg;

  localparam int unsigned RGB_W    = 24;
  localparam int unsigned CH_W     = 8;
  localparam int unsigned R_LSB    = 16;
  localparam int unsigned G_LSB    = 8;
  localparam int unsigned B_LSB    = 0;
  localparam int unsigned NUM_BARS = 8;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  localparam logic [RGB_W-1:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] COL_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] COL_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] COL_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] COL_BLACK   = 24'h000000;

  // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_timing_gen_if.sv
// hdmi_timing_gen_if: control inputs and video outputs of the HDMI raster source.
//   enable, pattern_sel, solid_rgb : run control and pattern selection (into the generator)
//   hdmi_d, hdmi_de, hdmi_hs,
//   hdmi_vs, frame_start           : registered video outputs (towards the pads)
// master = the generator, slave = the environment driving controls / consuming video.
interface hdmi_timing_gen_if;
  import hdmi_timing_pkg::*;

  logic             enable;
  logic [1:0]       pattern_sel;
  logic [RGB_W-1:0] solid_rgb;
  logic [RGB_W-1:0] hdmi_d;
  logic             hdmi_de;
  logic             hdmi_hs;
  logic             hdmi_vs;
  logic             frame_start;

  modport master (
    input  enable, pattern_sel, solid_rgb,
    output hdmi_d, hdmi_de, hdmi_hs, hdmi_vs, frame_start
  );

  modport slave (
    output enable, pattern_sel, solid_rgb,
    input  hdmi_d, hdmi_de, hdmi_hs, hdmi_vs, frame_start
  );
endinterface

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: combinational pixel colour for pattern coordinate (x, y).
//   x, y       : pattern coordinates (x may already be scroll-adjusted)
//   pattern    : pattern in force for the current frame
//   solid_rgb  : colour for the solid pattern
//   rgb_c      : resulting {R,G,B} colour (not gated by data enable)
module hdmi_pattern_gen
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned XW       = 11,
  parameter int unsigned YW       = 10
) (
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  pattern_e         pattern,
  input  logic [RGB_W-1:0] solid_rgb,
  output logic [RGB_W-1:0] rgb_c
);

  localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

  logic [2:0] bar_idx_c;

  // Bar index by compare chain; anything at or past the last boundary is the last bar.
  always_comb begin
    bar_idx_c = 3'(NUM_BARS - 1);
    for (int k = int'(NUM_BARS) - 2; k >= 0; k--) begin
      if (32'(x) < 32'((k + 1) * int'(BAR_W))) begin
        bar_idx_c = 3'(k);
      end
    end
  end

  // Pattern colour select.
  always_comb begin
    rgb_c = '0;
    case (pattern)
      PAT_BARS:  rgb_c = bar_colour(bar_idx_c);
      PAT_GRID:  rgb_c = ((5'(x) == 5'd0) || (5'(y) == 5'd0)) ? COL_WHITE : COL_BLACK;
      PAT_GRAD: begin
        rgb_c[R_LSB +: CH_W] = CH_W'(x);
        rgb_c[G_LSB +: CH_W] = CH_W'(y);
        rgb_c[B_LSB +: CH_W] = CH_W'(x) + CH_W'(y);
      end
      PAT_SOLID: rgb_c = solid_rgb;
      default:   rgb_c = '0;
    endcase
  end

endmodule

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: programmable H/V raster timing plus test-pattern source for HDMI pins.
//   clk   : pixel clock, rising edge
//   reset : synchronous, active-high
//   bus   : hdmi_timing_gen_if.master (enable/pattern_sel/solid_rgb in,
//           hdmi_d/de/hs/vs and frame_start out, all registered one clk after the counters)
// Optional macro HDMI_PATTERN_SCROLL_EN: adds an 8-bit frame counter and scrolls the
// bars/grid/gradient left by one pixel per frame.
module hdmi_timing_gen
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input logic               clk,
  input logic               reset,
  hdmi_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;
  logic             h_last_c;
  logic             v_last_c;
  logic             origin_c;
  logic             active_c;
  logic             hs_win_c;
  logic             vs_win_c;
  pattern_e         pat_q;
  pattern_e         pat_c;
  logic [RGB_W-1:0] solid_q;
  logic [RGB_W-1:0] solid_c;
  logic [RGB_W-1:0] pix_c;
  logic [HW-1:0]    x_c;

  assign h_last_c = (32'(h_cnt) == H_TOTAL - 1);
  assign v_last_c = (32'(v_cnt) == V_TOTAL - 1);
  assign origin_c = (h_cnt == '0) && (v_cnt == '0);
  assign active_c = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
  assign hs_win_c = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
  assign vs_win_c = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);

  // Raster counters; enable low parks them at the frame origin.
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last_c) begin
      h_cnt <= '0;
      v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Pattern/colour are captured at the frame origin; the bypass lets pixel (0,0)
  // already use the newly sampled values so the whole frame is consistent.
  assign pat_c   = origin_c ? pattern_e'(bus.pattern_sel) : pat_q;
  assign solid_c = origin_c ? bus.solid_rgb : solid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= PAT_BARS;
      solid_q <= '0;
    end else if (bus.enable && origin_c) begin
      pat_q   <= pat_c;
      solid_q <= solid_c;
    end
  end

`ifdef HDMI_PATTERN_SCROLL_EN
  logic [7:0]  frame_cnt;
  logic [HW-1:0] scroll_off;
  logic [HW:0]   x_sum_c;

  // scroll_off tracks frame_cnt mod H_ACTIVE so no divider is needed for the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt  <= '0;
      scroll_off <= '0;
    end else if (bus.enable && h_last_c && v_last_c) begin
      frame_cnt  <= frame_cnt + 8'd1;
      scroll_off <= ((frame_cnt == 8'hFF) || (32'(scroll_off) == H_ACTIVE - 1))
                    ? '0 : scroll_off + HW'(1);
    end
  end

  // Both terms are below H_ACTIVE in the active region, so one subtract wraps.
  assign x_sum_c = {1'b0, h_cnt} + {1'b0, scroll_off};
  assign x_c     = (32'(x_sum_c) >= H_ACTIVE) ? HW'(32'(x_sum_c) - H_ACTIVE) : HW'(x_sum_c);
`else
  assign x_c = h_cnt;
`endif

  hdmi_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (HW),
    .YW       (VW)
  ) u_pattern (
    .x         (x_c),
    .y         (v_cnt),
    .pattern   (pat_c),
    .solid_rgb (solid_c),
    .rgb_c     (pix_c)
  );

  // Output stage: one register for every video signal keeps them mutually aligned.
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      bus.hdmi_d      <= '0;
      bus.hdmi_de     <= 1'b0;
      bus.hdmi_hs     <= ~HS_POL;
      bus.hdmi_vs     <= ~VS_POL;
      bus.frame_start <= 1'b0;
    end else begin
      bus.hdmi_d      <= active_c ? pix_c : '0;
      bus.hdmi_de     <= active_c;
      bus.hdmi_hs     <= hs_win_c ? HS_POL : ~HS_POL;
      bus.hdmi_vs     <= vs_win_c ? VS_POL : ~VS_POL;
      bus.frame_start <= origin_c;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// tb_hdmi_timing_gen: self-checking bench for hdmi_timing_gen using small raster
// parameters (24x8 total, 16x4 active) and a frame-position reference model.
module tb_hdmi_timing_gen;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam bit HS_POL   = 1'b1;
  localparam bit VS_POL   = 1'b1;
  localparam logic [27:0] RST_V = {24'h0, 1'b0, ~HS_POL, ~VS_POL, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;

  hdmi_timing_gen_if bus();

  hdmi_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL   (HS_POL),   .VS_POL (VS_POL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [23:0] bar_ref [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [23:0] line0_ref [16] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
                                  24'h00FFFF, 24'h00FFFF, 24'h00FF00, 24'h00FF00,
                                  24'hFF00FF, 24'hFF00FF, 24'hFF0000, 24'hFF0000,
                                  24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000};

  // Reference model state: position within the frame since raster start.
  int          pos = 0;
  int          m_frames = 0;
  logic [1:0]  m_pat = 2'd0;
  logic [23:0] m_solid = 24'h0;
  logic [27:0] exp_v = 28'h0;
  int          cur_h = -1;
  int          cur_v = -1;

  logic [27:0] got;
  assign got = {bus.hdmi_d, bus.hdmi_de, bus.hdmi_hs, bus.hdmi_vs, bus.frame_start};

  function automatic logic [23:0] ref_pixel(input int x, input int y,
                                            input logic [1:0] pat, input logic [23:0] solid);
    int bar;
    case (pat)
      2'd0: begin
        bar = x / BAR_W;
        if (bar > 7) bar = 7;
        return bar_ref[bar];
      end
      2'd1:    return ((x % 32) == 0 || (y % 32) == 0) ? 24'hFFFFFF : 24'h000000;
      2'd2:    return {8'(x), 8'(y), 8'(x + y)};
      default: return solid;
    endcase
  endfunction

  // Advance one clock, then predict what the outputs must show for that edge.
  task automatic tick();
    logic r, en;
    logic [1:0] ps;
    logic [23:0] sr;
    int h, v, x;
    logic act;
    @(posedge clk);
    r  = reset;
    en = bus.enable;
    ps = bus.pattern_sel;
    sr = bus.solid_rgb;
    #1;
    if (r || !en) begin
      exp_v = RST_V;
      pos   = 0;
      cur_h = -1;
      cur_v = -1;
      if (r) begin
        m_pat    = 2'd0;
        m_solid  = 24'h0;
        m_frames = 0;
      end
    end else begin
      h = pos % H_TOTAL;
      v = pos / H_TOTAL;
      cur_h = h;
      cur_v = v;
      if (pos == 0) begin
        m_pat   = ps;
        m_solid = sr;
      end
      x = h;
`ifdef HDMI_PATTERN_SCROLL_EN
      x = (h + m_frames) % H_ACTIVE;
`endif
      act = (h < H_ACTIVE) && (v < V_ACTIVE);
      exp_v = {act ? ref_pixel(x, v, m_pat, m_solid) : 24'h0,
               act,
               ((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL,
               ((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL,
               (pos == 0)};
      pos = (pos + 1) % FRAME;
      if (pos == 0) m_frames = (m_frames + 1) % 256;
    end
  endtask

  task automatic restart(input logic [1:0] pat, input logic [23:0] solid);
    reset = 1'b1;
    bus.enable = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.pattern_sel = pat;
    bus.solid_rgb = solid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.pattern_sel = 2'($urandom);
    bus.solid_rgb = 24'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (got !== RST_V) begin
        errors++;
        $display("FAIL reset_values cycle %0d: got %h expected %h", i, got, RST_V);
      end
    end
  endtask

  task automatic test_timing();
    int de_line[8];
    logic e;
    restart(2'd0, 24'h0);
    foreach (de_line[i]) de_line[i] = 0;
    for (int t = 0; t < 2 * FRAME; t++) begin
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL timing_model t=%0d: got %h expected %h", t, got, exp_v);
      end
      if (bus.hdmi_de) de_line[(t / H_TOTAL) % V_TOTAL]++;
      e = ((t % H_TOTAL) >= 18) && ((t % H_TOTAL) <= 20);
      checks++;
      if (bus.hdmi_hs !== e) begin
        errors++;
        $display("FAIL hs_window t=%0d: got %b expected %b", t, bus.hdmi_hs, e);
      end
      e = (((t / H_TOTAL) % V_TOTAL) == 5) || (((t / H_TOTAL) % V_TOTAL) == 6);
      checks++;
      if (bus.hdmi_vs !== e) begin
        errors++;
        $display("FAIL vs_window t=%0d: got %b expected %b", t, bus.hdmi_vs, e);
      end
      e = ((t % FRAME) == 0);
      checks++;
      if (bus.frame_start !== e) begin
        errors++;
        $display("FAIL frame_start_period t=%0d: got %b expected %b", t, bus.frame_start, e);
      end
    end
    for (int l = 0; l < 8; l++) begin
      checks++;
      if (de_line[l] != ((l < 4) ? 32 : 0)) begin
        errors++;
        $display("FAIL de_per_line line %0d: got %0d expected %0d", l, de_line[l], (l < 4) ? 32 : 0);
      end
    end
  endtask

  task automatic test_bars();
    logic [23:0] e;
    restart(2'd0, 24'($urandom));
    for (int t = 0; t < FRAME; t++) begin
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL bars_model t=%0d: got %h expected %h", t, got, exp_v);
      end
      if (t < H_TOTAL) begin
        e = (t < H_ACTIVE) ? line0_ref[t] : 24'h0;
        checks++;
        if (bus.hdmi_d !== e) begin
          errors++;
          $display("FAIL bars_line0 x=%0d: got %h expected %h", t, bus.hdmi_d, e);
        end
      end
    end
  endtask

  task automatic test_pattern_switch();
    logic [23:0] e;
    int solid_cnt;
    restart(2'd0, 24'h0);
    solid_cnt = 0;
    for (int t = 0; t < 2 * FRAME; t++) begin
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL switch_model t=%0d: got %h expected %h", t, got, exp_v);
      end
      if (t == 50) begin
        bus.pattern_sel = 2'd3;
        bus.solid_rgb = 24'h123456;
      end
      if (t < FRAME) begin
        e = bus.hdmi_de ? line0_ref[t % H_TOTAL] : 24'h0;
        checks++;
        if (bus.hdmi_d !== e) begin
          errors++;
          $display("FAIL switch_frame0_bars t=%0d: got %h expected %h", t, bus.hdmi_d, e);
        end
      end else begin
        if (bus.hdmi_de && bus.hdmi_d === 24'h123456) solid_cnt++;
        if (!bus.hdmi_de) begin
          checks++;
          if (bus.hdmi_d !== 24'h0) begin
            errors++;
            $display("FAIL switch_blank_zero t=%0d: got %h expected %h", t, bus.hdmi_d, 24'h0);
          end
        end
      end
    end
    checks++;
    if (solid_cnt != 64) begin
      errors++;
      $display("FAIL switch_frame1_solid: got %0d expected %0d", solid_cnt, 64);
    end
  endtask

  task automatic test_gradient();
    int seen;
    restart(2'd2, 24'($urandom));
    seen = 0;
    for (int t = 0; t < FRAME; t++) begin
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL grad_model t=%0d: got %h expected %h", t, got, exp_v);
      end
      if (cur_h == 5 && cur_v == 3) begin
        seen++;
        checks++;
        if (bus.hdmi_d !== 24'h050308) begin
          errors++;
          $display("FAIL grad_pixel_5_3: got %h expected %h", bus.hdmi_d, 24'h050308);
        end
      end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL grad_pixel_seen: got %0d expected %0d", seen, 1);
    end
  endtask

  task automatic test_grid();
    logic [23:0] e;
    restart(2'd1, 24'($urandom));
    for (int t = 0; t < FRAME; t++) begin
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL grid_model t=%0d: got %h expected %h", t, got, exp_v);
      end
      if (cur_v <= 1 && cur_h >= 0 && cur_h < H_ACTIVE) begin
        e = (cur_v == 0 || cur_h == 0) ? 24'hFFFFFF : 24'h000000;
        checks++;
        if (bus.hdmi_d !== e) begin
          errors++;
          $display("FAIL grid_rows x=%0d y=%0d: got %h expected %h", cur_h, cur_v, bus.hdmi_d, e);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    int n;
    restart(2'($urandom), 24'($urandom));
    for (int t = 0; t < 2 * H_TOTAL + 8; t++) begin
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL drop_pre_model t=%0d: got %h expected %h", t, got, exp_v);
      end
    end
    bus.enable = 1'b0;
    tick();
    checks++;
    if (got !== RST_V) begin
      errors++;
      $display("FAIL drop_idle_next: got %h expected %h", got, RST_V);
    end
    n = $urandom_range(1, 10);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (got !== RST_V) begin
        errors++;
        $display("FAIL drop_idle_hold i=%0d: got %h expected %h", i, got, RST_V);
      end
    end
    bus.enable = 1'b1;
    bus.pattern_sel = 2'($urandom);
    bus.solid_rgb = 24'($urandom);
    for (int t = 0; t <= FRAME; t++) begin
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL drop_resume_model t=%0d: got %h expected %h", t, got, exp_v);
      end
      if (t == 0 || t == FRAME) begin
        checks++;
        if (bus.frame_start !== 1'b1) begin
          errors++;
          $display("FAIL drop_resume_frame_start t=%0d: got %b expected %b", t, bus.frame_start, 1'b1);
        end
      end
    end
  endtask

  task automatic test_random();
    restart(2'($urandom), 24'($urandom));
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 29) == 0) bus.pattern_sel = 2'($urandom);
      if ($urandom_range(0, 29) == 0) bus.solid_rgb = 24'($urandom);
      if (bus.enable && $urandom_range(0, 149) == 0) bus.enable = 1'b0;
      else if (!bus.enable && $urandom_range(0, 4) == 0) bus.enable = 1'b1;
      reset = ($urandom_range(0, 499) == 0);
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random_model t=%0d: got %h expected %h", t, got, exp_v);
      end
    end
    reset = 1'b0;
    bus.enable = 1'b1;
  endtask

`ifdef HDMI_PATTERN_SCROLL_EN
  task automatic test_scroll();
    logic [23:0] e;
    restart(2'd0, 24'h0);
    for (int t = 0; t < 2 * FRAME; t++) begin
      tick();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL scroll_model t=%0d: got %h expected %h", t, got, exp_v);
      end
      if (t == 0 || t == 1 || t == FRAME || t == FRAME + 1) begin
        e = (t == FRAME + 1) ? 24'hFFFF00 : 24'hFFFFFF;
        checks++;
        if (bus.hdmi_d !== e) begin
          errors++;
          $display("FAIL scroll_pixel t=%0d: got %h expected %h", t, bus.hdmi_d, e);
        end
      end
    end
  endtask
`endif

  initial begin
    bus.enable = 1'b0;
    bus.pattern_sel = 2'd0;
    bus.solid_rgb = 24'h0;
    test_reset();
    test_timing();
    test_bars();
    test_pattern_switch();
    test_gradient();
    test_grid();
    test_enable_drop();
    test_random();
`ifdef HDMI_PATTERN_SCROLL_EN
    test_scroll();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
